// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
//    Write-back scheduler and scoreboard for the 8x16-bit register file.
//    NUM_REQ write-back requesters (ALU, load unit, immediate path) share the
//    file's single write port. A round-robin arbiter picks one requester per
//    cycle and the winning request is registered onto the rf_* port in the
//    following cycle. A per-register busy scoreboard lets decode stall on
//    RAW/WAW hazards until the pending write-back has landed in the file.
//
// Ports
//    clk, reset        clock; synchronous active-high reset
//    req_valid/ready   per-requester handshake, ready is a one-hot grant
//    req_id/mode/data  packed per-requester write-back fields (i at [i*W +: W])
//                      mode: 00 full, 01 low byte, 10 high byte, 11 no-write
//    issue_valid/id    decode marks a destination as pending
//    issue_ready       issue accepted this cycle
//    chk_id1/chk_id2   source operands checked against the scoreboard
//    hazard            a checked source is pending
//    busy              scoreboard bits, one per implemented register
//    rf_rd3 .. rf_write_data3  register-file write port (rf_rd3 tied low)
//    wb_err            1-cycle pulse for a dropped write (mode 11 or bad id)
// -----------------------------------------------------------------------------
module regfile_wb_sched #(
   parameter int NUM_REQ  = 3,
   parameter int DATA_W   = 16,
   parameter int ID_W     = 4,
   parameter int NUM_REGS = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ID_W-1:0]     req_id,
   input  logic [NUM_REQ*2-1:0]        req_mode,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic                        issue_valid,
   input  logic [ID_W-1:0]             issue_id,
   output logic                        issue_ready,
   input  logic [ID_W-1:0]             chk_id1,
   input  logic [ID_W-1:0]             chk_id2,
   output logic                        hazard,
   output logic [NUM_REGS-1:0]         busy,
   output logic                        rf_rd3,
   output logic                        rf_wn3,
   output logic [1:0]                  rf_write_mode,
   output logic [ID_W-1:0]             rf_reg_id3,
   output logic [DATA_W-1:0]           rf_write_data3,
   output logic                        wb_err
);

   localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
   localparam logic [1:0] MODE_NONE = 2'b11;

   // Registered state
   logic [PTR_W-1:0]    r_ptr;
   logic [NUM_REGS-1:0] r_busy;
   logic                r_wn3;
   logic                r_err;
   logic [1:0]          r_mode;
   logic [ID_W-1:0]     r_id;
   logic [DATA_W-1:0]   r_data;

   // Arbiter results
   logic                w_found;
   logic [NUM_REQ-1:0]  w_grant;
   logic [PTR_W-1:0]    w_next_ptr;
   logic [ID_W-1:0]     w_sel_id;
   logic [1:0]          w_sel_mode;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_sel_ok;

   // Scoreboard helpers
   logic                w_issue_busy;
   logic                w_issue_in_range;
   logic                w_issue_acc;
   logic                w_hazard;
   logic [NUM_REGS-1:0] w_busy_next;

   // -------------------------------------------------------------------------
   // Round-robin arbiter: walk the requesters starting at r_ptr with wrap; the
   // first valid one wins. The inner loop over constant i keeps every select
   // a constant index into the packed request buses.
   // -------------------------------------------------------------------------
   always_comb begin : arb
      int idx;
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      idx        = 0;
      w_found    = 1'b0;
      w_grant    = '0;
      w_next_ptr = r_ptr;
      w_sel_id   = '0;
      w_sel_mode = MODE_NONE;
      w_sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == i && !w_found && req_valid[i] && !reset) begin
               w_found    = 1'b1;
               w_grant[i] = 1'b1;
               w_sel_id   = req_id[i*ID_W +: ID_W];
               w_sel_mode = req_mode[i*2 +: 2];
               w_sel_data = req_data[i*DATA_W +: DATA_W];
               w_next_ptr = PTR_W'((i + 1) % NUM_REQ);
            end
         end
      end
   end

   // A granted request is still consumed when it cannot write: no-write mode
   // or an id beyond the implemented registers turns into a wb_err pulse.
   assign w_sel_ok = (w_sel_mode != MODE_NONE) && (int'(w_sel_id) < NUM_REGS);

   // -------------------------------------------------------------------------
   // Scoreboard lookups and next state
   // -------------------------------------------------------------------------
   always_comb begin : sb
      w_issue_busy = 1'b0;
      w_hazard     = 1'b0;
      w_busy_next  = r_busy;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (issue_id == ID_W'(r) && r_busy[r])                 w_issue_busy = 1'b1;
         if ((chk_id1 == ID_W'(r) || chk_id2 == ID_W'(r)) && r_busy[r]) w_hazard = 1'b1;
         // Clear on the write that lands this edge; a same-edge issue to the
         // same register is applied after, so the set wins.
         if (r_wn3 && r_id == ID_W'(r))                          w_busy_next[r] = 1'b0;
         if (w_issue_acc && issue_id == ID_W'(r))                w_busy_next[r] = 1'b1;
      end
   end

   assign w_issue_in_range = int'(issue_id) < NUM_REGS;
   assign w_issue_acc      = issue_valid & ~w_issue_busy & w_issue_in_range & ~reset;

   // -------------------------------------------------------------------------
   // State registers. A reset also discards a registered write in flight.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         r_ptr  <= '0;
         r_busy <= '0;
         r_wn3  <= 1'b0;
         r_err  <= 1'b0;
         r_mode <= MODE_NONE;
         r_id   <= '0;
         r_data <= '0;
      end else begin
         r_busy <= w_busy_next;
         if (w_found) begin
            r_ptr  <= w_next_ptr;
            r_wn3  <= w_sel_ok;
            r_err  <= ~w_sel_ok;
            r_mode <= w_sel_ok ? w_sel_mode : MODE_NONE;
            r_id   <= w_sel_id;
            r_data <= w_sel_data;
         end else begin
            r_wn3  <= 1'b0;
            r_err  <= 1'b0;
            r_mode <= MODE_NONE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign req_ready      = w_grant;
   assign issue_ready    = w_issue_acc;
   assign hazard         = w_hazard;
   assign busy           = r_busy;
   assign rf_rd3         = 1'b0;
   assign rf_wn3         = r_wn3;
   assign rf_write_mode  = r_mode;
   assign rf_reg_id3     = r_id;
   assign rf_write_data3 = r_data;
   assign wb_err         = r_err;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_sched
//    Self-checking bench for regfile_wb_sched. Grant patterns come from a
//    table of vectors; every accepted transfer pushes its expected rf_* record
//    into a queue that a negedge monitor pops one cycle later. A small model of
//    the register file consumes the rf_* port so byte-merge results can be
//    checked. Multi-cycle corners (scoreboard, dropped writes, set/clear
//    collision, reset mid-operation) are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_wb_sched;

   localparam int NUM_REQ  = 3;
   localparam int DATA_W   = 16;
   localparam int ID_W     = 4;
   localparam int NUM_REGS = 8;
   localparam int NVEC     = 12;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ID_W-1:0]   req_id;
   logic [NUM_REQ*2-1:0]      req_mode;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      issue_valid;
   logic [ID_W-1:0]           issue_id;
   logic                      issue_ready;
   logic [ID_W-1:0]           chk_id1;
   logic [ID_W-1:0]           chk_id2;
   logic                      hazard;
   logic [NUM_REGS-1:0]       busy;
   logic                      rf_rd3;
   logic                      rf_wn3;
   logic [1:0]                rf_write_mode;
   logic [ID_W-1:0]           rf_reg_id3;
   logic [DATA_W-1:0]         rf_write_data3;
   logic                      wb_err;

   regfile_wb_sched #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_REGS(NUM_REGS)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
      .req_mode(req_mode), .req_data(req_data),
      .issue_valid(issue_valid), .issue_id(issue_id), .issue_ready(issue_ready),
      .chk_id1(chk_id1), .chk_id2(chk_id2), .hazard(hazard), .busy(busy),
      .rf_rd3(rf_rd3), .rf_wn3(rf_wn3), .rf_write_mode(rf_write_mode),
      .rf_reg_id3(rf_reg_id3), .rf_write_data3(rf_write_data3), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      int              due;
      logic            wn3;
      logic [1:0]      mode;
      logic [ID_W-1:0] id;
      logic [15:0]     data;
      logic            err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Called in the cycle the bench expects requester g to be granted.
   task automatic push_expect(input int g);
      exp_t            e;
      logic [ID_W-1:0] id;
      logic [1:0]      mode;
      logic            ok;
      id     = req_id[g*ID_W +: ID_W];
      mode   = req_mode[g*2 +: 2];
      ok     = (mode != 2'b11) && (id < 4'd8);
      e.due  = cyc + 1;
      e.wn3  = ok;
      e.err  = !ok;
      e.mode = mode;
      e.id   = id;
      e.data = req_data[g*DATA_W +: DATA_W];
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check("sb_wn3", rf_wn3, mon_e.wn3);
            check("sb_wb_err", wb_err, mon_e.err);
            if (mon_e.wn3) begin
               check("sb_mode", rf_write_mode, mon_e.mode);
               check("sb_id", rf_reg_id3, mon_e.id);
               check("sb_data", rf_write_data3, mon_e.data);
            end
         end else begin
            check("idle_wn3", rf_wn3, 1'b0);
            check("idle_wb_err", wb_err, 1'b0);
         end
      end
   end

   // ------------------------------------------------------ register file model
   logic [15:0] rf_model [NUM_REGS];

   always @(posedge clk) begin
      if (rf_wn3 === 1'b1 && rf_reg_id3 < 4'd8) begin
         case (rf_write_mode)
            2'b00:   rf_model[rf_reg_id3[2:0]]       <= rf_write_data3;
            2'b01:   rf_model[rf_reg_id3[2:0]][7:0]  <= rf_write_data3[7:0];
            2'b10:   rf_model[rf_reg_id3[2:0]][15:8] <= rf_write_data3[7:0];
            default: ;
         endcase
      end
   end

   // ----------------------------------------------------------------- helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_id    = '0;
      req_mode  = '0;
      req_data  = '0;
   endtask

   task automatic set_req(input int r, input logic [ID_W-1:0] id,
                          input logic [1:0] mode, input logic [15:0] data);
      req_valid[r]               = 1'b1;
      req_id[r*ID_W +: ID_W]     = id;
      req_mode[r*2 +: 2]         = mode;
      req_data[r*DATA_W +: DATA_W] = data;
   endtask

   function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
      int g;
      g = 0;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) g = i;
      return g;
   endfunction

   // ------------------------------------------------------------------ vectors
   typedef struct {
      logic [NUM_REQ-1:0]        valid;
      logic [NUM_REQ*ID_W-1:0]   ids;
      logic [NUM_REQ*2-1:0]      modes;
      logic [NUM_REQ*DATA_W-1:0] data;
      logic [NUM_REQ-1:0]        exp_ready;
   } vec_t;

   vec_t tbl [NVEC];

   initial begin
      // Valid patterns and grants, starting from pointer 0 after reset.
      logic [NUM_REQ-1:0] vpat [NVEC];
      logic [NUM_REQ-1:0] gpat [NVEC];
      vpat = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
               3'b000, 3'b010, 3'b011, 3'b101, 3'b110, 3'b001};
      gpat = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
               3'b000, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
      for (int v = 0; v < NVEC; v++) begin
         tbl[v].valid     = vpat[v];
         tbl[v].ids       = {4'd3, 4'd2, 4'd1};
         tbl[v].modes     = 6'b00_00_00;
         tbl[v].data      = {16'(16'hC000 + v), 16'(16'hB000 + v), 16'(16'hA000 + v)};
         tbl[v].exp_ready = gpat[v];
      end
      for (int r = 0; r < NUM_REGS; r++) rf_model[r] = '0;

      reset       = 1'b1;
      clear_reqs();
      issue_valid = 1'b0;
      issue_id    = '0;
      chk_id1     = '0;
      chk_id2     = '0;

      // ---- reset: requests and issues are refused while reset is high
      step();
      step();
      mon_en      = 1'b1;
      req_valid   = 3'b111;
      issue_valid = 1'b1;
      issue_id    = 4'd1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 3'b000);
      check("rst_issue_ready", issue_ready, 1'b0);
      check("rst_busy", busy, 8'h00);
      check("rst_rf_mode", rf_write_mode, 2'b11);
      check("rst_rf_id", rf_reg_id3, 4'd0);
      check("rst_rf_data", rf_write_data3, 16'h0000);
      step();
      reset       = 1'b0;
      clear_reqs();
      issue_valid = 1'b0;

      // ---- idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_mode", rf_write_mode, 2'b11);
         check("idle_busy", busy, 8'h00);
         check("idle_req_ready", req_ready, 3'b000);
         check("idle_rd3", rf_rd3, 1'b0);
         step();
      end

      // ---- table-driven round-robin grants
      for (int v = 0; v < NVEC; v++) begin
         req_valid = tbl[v].valid;
         req_id    = tbl[v].ids;
         req_mode  = tbl[v].modes;
         req_data  = tbl[v].data;
         if (tbl[v].exp_ready != '0) push_expect(oh_idx(tbl[v].exp_ready));
         @(negedge clk);
         check($sformatf("vec%0d_ready", v), req_ready, tbl[v].exp_ready);
         step();
      end
      clear_reqs();
      @(negedge clk);
      check("tbl_busy", busy, 8'h00);
      step();

      // ---- issue id 5, then write BEEF to it (pointer is 1 here)
      issue_valid = 1'b1;
      issue_id    = 4'd5;
      chk_id1     = 4'd5;
      @(negedge clk);
      check("a_issue_ready", issue_ready, 1'b1);
      check("a_hazard_pre", hazard, 1'b0);
      step();
      issue_valid = 1'b0;
      set_req(0, 4'd5, 2'b00, 16'hBEEF);
      push_expect(0);
      @(negedge clk);
      check("a_busy_set", busy, 8'h20);
      check("a_hazard_set", hazard, 1'b1);
      check("a_ready", req_ready, 3'b001);
      step();
      clear_reqs();
      @(negedge clk);
      check("a_busy_inflight", busy, 8'h20);
      check("a_hazard_inflight", hazard, 1'b1);
      step();
      @(negedge clk);
      check("a_busy_clear", busy, 8'h00);
      check("a_hazard_clear", hazard, 1'b0);
      check("a_reg5", rf_model[5], 16'hBEEF);
      chk_id1 = '0;
      step();

      // ---- byte writes to id 2 via requester 1 (pointer 1)
      set_req(1, 4'd2, 2'b01, 16'h00AB);
      push_expect(1);
      @(negedge clk);
      check("b_ready_lo", req_ready, 3'b010);
      step();
      clear_reqs();
      set_req(1, 4'd2, 2'b10, 16'h00CD);
      push_expect(1);
      @(negedge clk);
      check("b_ready_hi", req_ready, 3'b010);
      step();
      clear_reqs();
      step();
      @(negedge clk);
      check("b_reg2", rf_model[2], 16'hCDAB);
      step();

      // ---- dropped writes: issue 3, then mode 11 and bad id (pointer 2)
      issue_valid = 1'b1;
      issue_id    = 4'd3;
      @(negedge clk);
      check("c_issue_ready", issue_ready, 1'b1);
      step();
      issue_valid = 1'b0;
      set_req(1, 4'd3, 2'b11, 16'hFFFF);
      set_req(2, 4'd9, 2'b00, 16'h1111);
      push_expect(2);
      @(negedge clk);
      check("c_ready_req2", req_ready, 3'b100);
      check("c_busy", busy, 8'h08);
      step();
      req_valid[2] = 1'b0;
      push_expect(1);
      @(negedge clk);
      check("c_ready_req1", req_ready, 3'b010);
      step();
      clear_reqs();
      @(negedge clk);
      check("c_busy_kept1", busy, 8'h08);
      step();
      @(negedge clk);
      check("c_busy_kept2", busy, 8'h08);
      step();

      // ---- issue id 4 while its write-back is on the port (pointer 2)
      set_req(0, 4'd4, 2'b00, 16'h1234);
      push_expect(0);
      @(negedge clk);
      check("d_ready", req_ready, 3'b001);
      step();
      clear_reqs();
      issue_valid = 1'b1;
      issue_id    = 4'd4;
      @(negedge clk);
      check("d_wn3_on_port", rf_wn3, 1'b1);
      check("d_issue_ready", issue_ready, 1'b1);
      step();
      @(negedge clk);
      check("d_busy_set_wins", busy, 8'h18);
      check("d_issue_busy", issue_ready, 1'b0);
      check("d_reg4", rf_model[4], 16'h1234);
      issue_id = 4'd9;
      #1;
      check("d_issue_bad_id", issue_ready, 1'b0);
      chk_id1 = 4'd9;
      chk_id2 = 4'd0;
      #1;
      check("d_hazard_bad_id", hazard, 1'b0);
      chk_id2 = 4'd4;
      #1;
      check("d_hazard_id4", hazard, 1'b1);
      issue_valid = 1'b0;
      chk_id1     = '0;
      chk_id2     = '0;
      step();

      // ---- reset mid-operation (pointer 1)
      set_req(1, 4'd6, 2'b00, 16'h5A5A);
      push_expect(1);
      @(negedge clk);
      check("e_ready", req_ready, 3'b010);
      step();
      clear_reqs();
      set_req(0, 4'd1, 2'b00, 16'h7777);
      reset       = 1'b1;
      issue_valid = 1'b1;
      issue_id    = 4'd6;
      @(negedge clk);
      check("e_rst_req_ready", req_ready, 3'b000);
      check("e_rst_issue_ready", issue_ready, 1'b0);
      step();
      reset       = 1'b0;
      issue_valid = 1'b0;
      clear_reqs();
      @(negedge clk);
      check("e_busy_cleared", busy, 8'h00);
      check("e_mode_reset", rf_write_mode, 2'b11);
      step();
      // Pointer restarts at 0 after reset.
      set_req(0, 4'd1, 2'b00, 16'h0101);
      set_req(1, 4'd2, 2'b00, 16'h0202);
      set_req(2, 4'd3, 2'b00, 16'h0303);
      push_expect(0);
      @(negedge clk);
      check("e_ptr_reset", req_ready, 3'b001);
      step();
      clear_reqs();

      // ---- drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
      check("sb_drained", exp_q.size(), 0);
      step();
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
